formula_n_fsm: RTL and testbench
================================

# formula_n_fsm

- Parametrised successor of the three-term nested-root FSM.
- Computes res = isqrt(x[0] + isqrt(x[1] + … + isqrt(x[N-1]))) for N terms of width W, using one external isqrt instance shared sequentially.
- Captures arguments on a valid/ready handshake, so the caller need not hold them. Sits between an argument source and a single isqrt core.

## Interface
Parameters:
- N, default 3: number of terms, ≥1.
- W, default 32: argument/result width, even, ≥4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- arg_vld  in  1  argument set offered.
- arg_rdy  out  1  block can accept an argument set.
- args  in  N×W packed, [N-1:0][W-1:0]  terms; args[0] is outermost, args[N-1] innermost.
- res_vld  out  1  one-cycle pulse, res valid.
- res  out  W  result, zero-extended from W/2.
- res_sat  out  1  only when FORMULA_N_FSM_SAT_EN is defined; a saturation occurred in this result.
- isqrt_x_vld  out  1  request to isqrt.
- isqrt_x  out  W  isqrt operand.
- isqrt_y_vld  in  1  isqrt response valid.
- isqrt_y  in  W/2  isqrt response.

## Operation
- States are ST_IDLE and ST_WAIT. A down-counter idx ($clog2(N) bits, min 1) tracks the term being consumed.
- Accept: arg_vld & arg_rdy.
  - args is latched into a register bank.
  - In the same cycle, isqrt_x = args[N-1] is driven from the input directly, with isqrt_x_vld=1.
  - idx <= N-1, state <= ST_WAIT.
- ST_WAIT with isqrt_y_vld and idx>0:
  - isqrt_x = bank[idx-1] + isqrt_y, with isqrt_x_vld=1, driven combinationally in that cycle.
  - idx <= idx-1.
- ST_WAIT with isqrt_y_vld and idx==0:
  - res <= isqrt_y zero-extended, res_vld <= 1 next cycle.
  - state <= ST_IDLE.
- arg_rdy = (state==ST_IDLE). It is combinational and does not depend on arg_vld.
- Exactly N isqrt requests per argument set, never more than one outstanding.
- Ignored inputs:
  - isqrt_y_vld in ST_IDLE.
  - arg_vld in ST_WAIT. The argument source must hold its offer until it is accepted.
- When isqrt_x_vld=0, isqrt_x is driven to 0 (never X).
- Sum width:
  - W-bit add of a W-bit term and a zero-extended W/2-bit response.
  - Without the macro, overflow wraps modulo 2^W.
- N=1: a single request with isqrt_x=args[0]. The first response completes the operation.

## Timing
- Reset values:
  - state=ST_IDLE, idx=0, res_vld=0, res=0, res_sat=0, bank=0.
  - arg_rdy=1 once reset is deasserted.
  - isqrt_x_vld=0, isqrt_x=0.
- Reset asserted mid-operation:
  - Immediate return to ST_IDLE; any operation in flight is abandoned with no res_vld.
  - The isqrt core must share this reset so no stale response arrives afterwards.
- Latency: res_vld is asserted 1 cycle after the Nth isqrt_y_vld. Total = sum of the N isqrt latencies + 1.
- res holds its value until the next completion; it is not cleared in ST_IDLE.
- Back-to-back operation: a new set may be accepted in the same cycle res_vld is high.
- Minimum spacing between accepts is (sum of isqrt latencies + 1) cycles.

## Configuration
- FORMULA_N_FSM_SAT_EN defined:
  - Each W-bit sum saturates to 2^W-1 on carry-out.
  - res_sat latches 1 if any sum in the current operation saturated. It is cleared on accept and presented alongside res_vld/res.
- Macro undefined:
  - Sums wrap.
  - The res_sat port and its register are absent.

## Structure
- Package formula_n_pkg holds:
  - state enum state_t {ST_IDLE, ST_WAIT}.
  - Function sat_add(W-bit, W/2-bit) returning sum and carry.
- The argument bank is a natural sub-module: formula_n_arg_bank.
  - Parametrised N, W.
  - Write-all on accept, one read port indexed by idx-1.
- The isqrt core stays outside this block; the testbench instantiates it.

## Test plan
Unless noted, N=3, W=32, with a real isqrt of latency 1 and of latency 4.
- Basic: args={a=13,b=5,c=16}.
  - Requests 16, 9, 16 on isqrt_x; res=4.
  - res_vld is a single pulse 1 cycle after the third isqrt_y_vld.
- Wrap (macro off): args={a=0, b=0xFFFF_FFFF, c=0xFFFF_FFFF}.
  - Second request = 0x0000_FFFE; res=15.
- Saturate (macro on): same args as Wrap.
  - Second request = 0xFFFF_FFFF; res=255, res_sat=1.
  - Next operation, args={13,5,16}: res_sat=0.
- Handshake:
  - arg_vld held high continuously with changing args. arg_rdy=0 in ST_WAIT.
  - Only args present at accept cycles are used. Back-to-back accepts occur in the res_vld cycle.
- Reset mid-operation: assert rst low after the 2nd request.
  - No res_vld; outputs return to reset values.
  - Next operation with {13,5,16} gives res=4.
- N=1, W=16: args={0xFFFF} → res=255. N=5 random sweep compared against a reference model.

Source files
------------

// File: rtl/formula_n_pkg.sv
// Shared state type and W-bit add helper for the parametrised nested-root FSM.
package formula_n_pkg;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam int MAX_W  = 128;
  localparam int HALF_W = MAX_W / 2;

  typedef struct packed {
    logic             carry;
    logic [MAX_W-1:0] sum;
  } add_t;

  // Adds a w-bit term to a zero-extended response; clamps to all-ones on carry when sat_en is set.
  function automatic add_t sat_add(input logic [MAX_W-1:0]  a,
                                   input logic [HALF_W-1:0] b,
                                   input logic [7:0]        w,
                                   input logic              sat_en);
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] mask;
    add_t             r;
    mask    = (MAX_W'(1) << w) - MAX_W'(1);
    full    = {1'b0, a} + {{(HALF_W + 1){1'b0}}, b};
    r.carry = full[w];
    r.sum   = full[MAX_W-1:0] & mask;
    if (sat_en && r.carry) r.sum = mask;
    return r;
  endfunction

endpackage

// File: rtl/formula_n_arg_bank.sv
// Argument register bank: captures all N terms on accept, one indexed read port.
module formula_n_arg_bank #(
  parameter int N  = 3,
  parameter int W  = 32,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic [N-1:0][W-1:0] i_args,
  input  logic [IW-1:0]       i_rd_idx,
  output logic [W-1:0]        o_rd_data
);

  logic [N-1:0][W-1:0] r_bank;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank <= '0;
    end else if (i_we) begin
      r_bank <= i_args;
    end
  end

  // Out-of-range indices only occur when the read is not consumed; return 0 for them.
  assign o_rd_data = (int'(i_rd_idx) < N) ? r_bank[i_rd_idx] : '0;

endmodule

// File: rtl/formula_n_fsm.sv
// res = isqrt(x[0] + isqrt(x[1] + ... + isqrt(x[N-1]))) through one shared external isqrt core.
// Define FORMULA_N_FSM_SAT_EN for saturating sums and the res_sat output; default build wraps.
module formula_n_fsm
  import formula_n_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arg_vld,
  output logic                arg_rdy,
  input  logic [N-1:0][W-1:0] args,
  output logic                res_vld,
  output logic [W-1:0]        res,
`ifdef FORMULA_N_FSM_SAT_EN
  output logic                res_sat,
`endif
  output logic                isqrt_x_vld,
  output logic [W-1:0]        isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [W/2-1:0]      isqrt_y
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
`ifdef FORMULA_N_FSM_SAT_EN
  localparam logic          SAT_EN = 1'b1;
`else
  localparam logic          SAT_EN = 1'b0;
`endif

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_res_vld;
  logic [W-1:0]  r_res;
`ifdef FORMULA_N_FSM_SAT_EN
  logic          r_sat;
`endif

  logic          w_accept;
  logic          w_step;
  logic          w_done;
  logic [W-1:0]  w_bank_rd;
  logic [W-1:0]  w_sum;
  add_t          w_add;
  logic          w_unused_add;

  formula_n_arg_bank #(.N(N), .W(W), .IW(IW)) u_bank (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_we      (w_accept),
    .i_args    (args),
    .i_rd_idx  (r_idx - IW'(1)),
    .o_rd_data (w_bank_rd)
  );

  assign arg_rdy  = (r_state == ST_IDLE);
  assign w_accept = arg_vld & arg_rdy;
  assign w_step   = (r_state == ST_WAIT) & isqrt_y_vld & (r_idx != '0);
  assign w_done   = (r_state == ST_WAIT) & isqrt_y_vld & (r_idx == '0);

  assign w_add        = sat_add(MAX_W'(w_bank_rd), HALF_W'(isqrt_y), 8'(W), SAT_EN);
  assign w_sum        = w_add.sum[W-1:0];
  assign w_unused_add = ^{w_add.carry, w_add.sum[MAX_W-1:W]};

  // The innermost term goes out straight from the input so the first request costs no cycle.
  assign isqrt_x_vld = w_accept | w_step;
  assign isqrt_x     = w_accept ? args[N-1] : (w_step ? w_sum : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_res_vld <= 1'b0;
      r_res     <= '0;
`ifdef FORMULA_N_FSM_SAT_EN
      r_sat     <= 1'b0;
`endif
    end else begin
      r_res_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx   <= LAST;
            r_state <= ST_WAIT;
`ifdef FORMULA_N_FSM_SAT_EN
            r_sat   <= 1'b0;
`endif
          end
        end
        ST_WAIT: begin
          if (w_step) begin
            r_idx <= r_idx - IW'(1);
`ifdef FORMULA_N_FSM_SAT_EN
            if (w_add.carry) r_sat <= 1'b1;
`endif
          end else if (w_done) begin
            r_res     <= W'(isqrt_y);
            r_res_vld <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign res_vld = r_res_vld;
  assign res     = r_res;
`ifdef FORMULA_N_FSM_SAT_EN
  assign res_sat = r_sat;
`endif

endmodule

// File: tb/tb_formula_n_fsm.sv
// Scoreboard bench: three DUT builds (N=3/W=32, N=5/W=32, N=1/W=16), each with its own isqrt responder.
module tb_formula_n_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int nk[3] = '{3, 5, 1};
  int wk[3] = '{32, 32, 16};

  logic        argVld[3];
  logic [31:0] argArr[3][5];
  logic        rdyArr[3], resVldArr[3], xVldArr[3], satArr[3], yVldArr[3];
  logic [31:0] resArr[3], xArr[3], yArr[3];

  logic [2:0][31:0] argsA;
  logic [4:0][31:0] argsB;
  logic [0:0][15:0] argsC;
  logic [15:0]      resC, xC;

  int          latArr[3];
  int          cnt[3];
  logic [31:0] pendY[3];

  logic [31:0] reqQ[3][$];
  logic [31:0] resQ[3][$];
  logic        satQ[3][$];

  int          yCnt[3], acceptCnt[3], resCnt[3], b2b[3], opIdx[3];
  bit          pendRes[3], outst[3];
  logic [31:0] lastRes[3];
  logic        lastSat[3];
  logic [31:0] opReq[3][5];

  always_comb begin
    for (int i = 0; i < 3; i++) argsA[i] = argArr[0][i];
    for (int i = 0; i < 5; i++) argsB[i] = argArr[1][i];
    argsC[0] = argArr[2][0][15:0];
  end

  assign resArr[2] = {16'h0, resC};
  assign xArr[2]   = {16'h0, xC};
`ifndef FORMULA_N_FSM_SAT_EN
  assign satArr[0] = 1'b0;
  assign satArr[1] = 1'b0;
  assign satArr[2] = 1'b0;
`endif

  formula_n_fsm #(.N(3), .W(32)) dutA (
    .clk(clk), .rst(rst), .arg_vld(argVld[0]), .arg_rdy(rdyArr[0]), .args(argsA),
    .res_vld(resVldArr[0]), .res(resArr[0]),
`ifdef FORMULA_N_FSM_SAT_EN
    .res_sat(satArr[0]),
`endif
    .isqrt_x_vld(xVldArr[0]), .isqrt_x(xArr[0]), .isqrt_y_vld(yVldArr[0]), .isqrt_y(yArr[0][15:0])
  );

  formula_n_fsm #(.N(5), .W(32)) dutB (
    .clk(clk), .rst(rst), .arg_vld(argVld[1]), .arg_rdy(rdyArr[1]), .args(argsB),
    .res_vld(resVldArr[1]), .res(resArr[1]),
`ifdef FORMULA_N_FSM_SAT_EN
    .res_sat(satArr[1]),
`endif
    .isqrt_x_vld(xVldArr[1]), .isqrt_x(xArr[1]), .isqrt_y_vld(yVldArr[1]), .isqrt_y(yArr[1][15:0])
  );

  formula_n_fsm #(.N(1), .W(16)) dutC (
    .clk(clk), .rst(rst), .arg_vld(argVld[2]), .arg_rdy(rdyArr[2]), .args(argsC),
    .res_vld(resVldArr[2]), .res(resC),
`ifdef FORMULA_N_FSM_SAT_EN
    .res_sat(satArr[2]),
`endif
    .isqrt_x_vld(xVldArr[2]), .isqrt_x(xC), .isqrt_y_vld(yVldArr[2]), .isqrt_y(yArr[2][7:0])
  );

  function automatic logic [31:0] isqrt(input logic [31:0] v);
    longint r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(v)) r = t;
    end
    return 32'(r);
  endfunction

  // Reference: evaluate the nested roots from the innermost term outward with plain arithmetic.
  function automatic void model(input int k);
    longint lim, acc, s;
    bit     sat;
    lim = longint'(1) << wk[k];
    acc = 0;
    sat = 1'b0;
    for (int i = nk[k] - 1; i >= 0; i--) begin
      s = (longint'(argArr[k][i]) & (lim - 1)) + acc;
      if (s >= lim) begin
`ifdef FORMULA_N_FSM_SAT_EN
        s   = lim - 1;
        sat = 1'b1;
`else
        s = s - lim;
`endif
      end
      reqQ[k].push_back(32'(s));
      acc = longint'(isqrt(32'(s)));
    end
    resQ[k].push_back(32'(acc));
    satQ[k].push_back(sat);
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  // isqrt core model: configurable latency, answers each request exactly once.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        cnt[k]     <= 0;
        yVldArr[k] <= 1'b0;
        yArr[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        yVldArr[k] <= 1'b0;
        if (cnt[k] == 1) begin
          yVldArr[k] <= 1'b1;
          yArr[k]    <= pendY[k];
        end
        if (cnt[k] > 0) cnt[k] <= cnt[k] - 1;
        if (xVldArr[k]) begin
          if (latArr[k] <= 1) begin
            yVldArr[k] <= 1'b1;
            yArr[k]    <= isqrt(xArr[k]);
          end else begin
            pendY[k] <= isqrt(xArr[k]);
            cnt[k]   <= latArr[k] - 1;
          end
        end
      end
    end
  end

  // Monitor: pushes expectations on accepts, pops and compares on every DUT presentation.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        reqQ[k].delete();
        resQ[k].delete();
        satQ[k].delete();
        yCnt[k]    = 0;
        pendRes[k] = 1'b0;
        outst[k]   = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pendRes[k] || resVldArr[k])
          checkOutput("res_vld_timing", k, 32'(resVldArr[k]), 32'(pendRes[k]));
        pendRes[k] = 1'b0;
        if (resVldArr[k]) begin
          resCnt[k]++;
          lastRes[k] = resArr[k];
          lastSat[k] = satArr[k];
          checkOutput("res_expected", k, 32'(resQ[k].size() != 0), 32'(1));
          if (resQ[k].size() != 0) begin
            checkOutput("res", k, resArr[k], resQ[k].pop_front());
`ifdef FORMULA_N_FSM_SAT_EN
            checkOutput("res_sat", k, 32'(satArr[k]), 32'(satQ[k].pop_front()));
`else
            void'(satQ[k].pop_front());
`endif
          end
        end
        checkOutput("arg_rdy", k, 32'(rdyArr[k]), 32'(resQ[k].size() == 0));
        if (argVld[k] && rdyArr[k]) begin
          if (resVldArr[k]) b2b[k]++;
          model(k);
          yCnt[k]  = 0;
          opIdx[k] = 0;
          acceptCnt[k]++;
        end
        if (yVldArr[k]) begin
          outst[k] = 1'b0;
          yCnt[k]++;
          if (yCnt[k] == nk[k]) pendRes[k] = 1'b1;
        end
        if (xVldArr[k]) begin
          checkOutput("one_outstanding", k, 32'(outst[k]), 32'(0));
          outst[k] = 1'b1;
          if (opIdx[k] < 5) opReq[k][opIdx[k]] = xArr[k];
          opIdx[k]++;
          checkOutput("req_expected", k, 32'(reqQ[k].size() != 0), 32'(1));
          if (reqQ[k].size() != 0) checkOutput("isqrt_x", k, xArr[k], reqQ[k].pop_front());
        end else begin
          checkOutput("isqrt_x_idle", k, xArr[k], 32'(0));
        end
      end
    end
  end

  function automatic logic [31:0] randArg(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'($urandom_range(0, 100));
      1:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 2000));
      default: v = $urandom;
    endcase
    if (w == 16) v = v & 32'h0000_FFFF;
    return v;
  endfunction

  // Offers the argument set already placed in argArr[k] until it is accepted; returns #1 after an edge.
  task automatic applyStimulus(input int k);
    int start;
    int t;
    start     = acceptCnt[k];
    t         = 0;
    argVld[k] = 1'b1;
    while (acceptCnt[k] == start && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1 argVld[k] = 1'b0;
    checkOutput("accept_count", k, 32'(acceptCnt[k] - start), 32'(1));
  endtask

  task automatic waitDrain(input int k);
    int t;
    t = 0;
    while (resQ[k].size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    checkOutput("drain", k, 32'(resQ[k].size()), 32'(0));
  endtask

  task automatic runA(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    argArr[0][0] = a;
    argArr[0][1] = b;
    argArr[0][2] = c;
    applyStimulus(0);
    waitDrain(0);
  endtask

  initial begin
    int lats[2];
    int resBefore;
    int t;
    lats = '{1, 4};
    for (int k = 0; k < 3; k++) begin
      argVld[k] = 1'b0;
      latArr[k] = 1;
      for (int i = 0; i < 5; i++) argArr[k][i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_res_vld", 0, 32'(resVldArr[0]), 32'(0));
    checkOutput("reset_res", 0, resArr[0], 32'(0));
    checkOutput("reset_isqrt_x_vld", 0, 32'(xVldArr[0]), 32'(0));
    checkOutput("reset_isqrt_x", 0, xArr[0], 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) checkOutput("arg_rdy_after_reset", k, 32'(rdyArr[k]), 32'(1));
    @(posedge clk);
    #1;

    $display("[TB] directed N=3 runs at isqrt latency 1 and 4");
    for (int li = 0; li < 2; li++) begin
      latArr[0] = lats[li];
      runA(32'd13, 32'd5, 32'd16);
      checkOutput("basic_res", 0, lastRes[0], 32'd4);
      checkOutput("basic_req0", 0, opReq[0][0], 32'd16);
      checkOutput("basic_req1", 0, opReq[0][1], 32'd9);
      checkOutput("basic_req2", 0, opReq[0][2], 32'd16);
      runA(32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef FORMULA_N_FSM_SAT_EN
      checkOutput("sat_req1", 0, opReq[0][1], 32'hFFFF_FFFF);
      checkOutput("sat_res", 0, lastRes[0], 32'd255);
      checkOutput("sat_flag", 0, 32'(lastSat[0]), 32'(1));
`else
      checkOutput("wrap_req1", 0, opReq[0][1], 32'h0000_FFFE);
      checkOutput("wrap_res", 0, lastRes[0], 32'd15);
`endif
      runA(32'd13, 32'd5, 32'd16);
      checkOutput("after_wrap_res", 0, lastRes[0], 32'd4);
`ifdef FORMULA_N_FSM_SAT_EN
      checkOutput("sat_flag_cleared", 0, 32'(lastSat[0]), 32'(0));
`endif
    end

    $display("[TB] handshake with arg_vld held high and changing args");
    b2b[0]    = 0;
    argVld[0] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 3; i++) argArr[0][i] = randArg(32);
      latArr[0] = $urandom_range(1, 4);
      @(posedge clk);
      #1;
    end
    argVld[0] = 1'b0;
    waitDrain(0);
    checkOutput("back_to_back_accept", 0, 32'(b2b[0] > 0), 32'(1));

    $display("[TB] random sweeps");
    for (int n = 0; n < 30; n++) begin
      latArr[1] = $urandom_range(1, 4);
      for (int i = 0; i < 5; i++) argArr[1][i] = randArg(32);
      applyStimulus(1);
      waitDrain(1);
    end
    for (int n = 0; n < 20; n++) begin
      latArr[0] = lats[$urandom_range(0, 1)];
      runA(randArg(32), randArg(32), randArg(32));
    end

    $display("[TB] N=1 W=16");
    for (int li = 0; li < 2; li++) begin
      latArr[2]    = (li == 0) ? 1 : 3;
      argArr[2][0] = 32'h0000_FFFF;
      applyStimulus(2);
      waitDrain(2);
      checkOutput("n1_res", 2, lastRes[2], 32'd255);
    end
    for (int n = 0; n < 10; n++) begin
      latArr[2]    = $urandom_range(1, 4);
      argArr[2][0] = randArg(16);
      applyStimulus(2);
      waitDrain(2);
    end

    $display("[TB] reset asserted mid-operation");
    latArr[0]    = 4;
    argArr[0][0] = 32'd13;
    argArr[0][1] = 32'd5;
    argArr[0][2] = 32'd16;
    resBefore    = resCnt[0];
    applyStimulus(0);
    t = 0;
    while (opIdx[0] < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1 rst = 1'b0;
    checkOutput("reset_after_req2", 0, 32'(opIdx[0]), 32'(2));
    @(negedge clk);
    checkOutput("midreset_res_vld", 0, 32'(resVldArr[0]), 32'(0));
    checkOutput("midreset_isqrt_x_vld", 0, 32'(xVldArr[0]), 32'(0));
    checkOutput("midreset_isqrt_x", 0, xArr[0], 32'(0));
    checkOutput("midreset_res", 0, resArr[0], 32'(0));
    checkOutput("midreset_arg_rdy", 0, 32'(rdyArr[0]), 32'(1));
`ifdef FORMULA_N_FSM_SAT_EN
    checkOutput("midreset_res_sat", 0, 32'(satArr[0]), 32'(0));
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_res_after_reset", 0, 32'(resCnt[0]), 32'(resBefore));
    latArr[0] = 1;
    runA(32'd13, 32'd5, 32'd16);
    checkOutput("post_reset_res", 0, lastRes[0], 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
